// File: rtl/joybus_pkg.sv
// Shared types and constants for the Joybus transmitter.
// The JOYBUS_TX_CRC_EN build option uses CRC8_POLY and the S_CRC state.
package joybus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BITS,
    S_CRC,
    S_STOP,
    S_ABORT,
    S_DONE
  } state_e;

  // Four line levels per symbol, level 0 in the MSB; 0 = L, 1 = H.
  // In ENC_STOP the last level is released rather than driven high.
  localparam logic [3:0] ENC_ZERO  = 4'b0001;
  localparam logic [3:0] ENC_ONE   = 4'b0111;
  localparam logic [3:0] ENC_STOP  = 4'b0011;

  localparam logic [7:0] CRC8_POLY = 8'h85;

endpackage

// File: rtl/joybus_crc8.sv
// Serial CRC-8 (poly 0x85, init 0x00), one bit per enable, MSB-first.
// Direct form: yields the augmented remainder without trailing zero bits.
module joybus_crc8
  import joybus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       data,
  output logic [7:0] rem
);

  logic [7:0] rem_q;
  logic       fb;

  assign fb  = rem_q[7] ^ data;
  assign rem = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else if (enable) begin
      rem_q <= {rem_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/joybus_tx_engine.sv
// Joybus response serialiser: byte stream -> four-level line code plus stop bit.
// Define JOYBUS_TX_CRC_EN to append the CRC-8 checksum byte after the payload.
module joybus_tx_engine
  import joybus_pkg::*;
#(
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_BYTES   = 33,
  parameter int CNT_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             data_tx,
  output logic             data_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int               SUB_W    = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(LEVEL_WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       n_bit_counter_q, n_bit_counter_d;
  logic [1:0]       lvl_q, lvl_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             data_tx_q, data_tx_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, done_q, underrun_q;
  logic             accept, sub_end, lvl_end, bit_end, more_payload;
  logic [3:0]       sym_d;

`ifdef JOYBUS_TX_CRC_EN
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] crc_rem;

  // Fold each payload bit in on its first cycle so the remainder is final by the byte end.
  assign crc_en = (state_q == S_BITS) && (lvl_q == 2'd0) && (sub_q == '0);

  joybus_crc8 u_crc (
    .clk    (sample_clk),
    .reset  (reset | crc_clr),
    .enable (crc_en),
    .data   (shift_q[7]),
    .rem    (crc_rem)
  );
`endif

  assign tx_ready     = busy_q && !hold_full_q && (acc_q < count_q);
  assign accept       = tx_valid && tx_ready;
  assign sub_end      = (sub_q == SUB_LAST);
  assign lvl_end      = sub_end && (lvl_q == 2'd3);
  assign bit_end      = lvl_end && (n_bit_counter_q == 3'd7);
  assign more_payload = (sent_q < count_q);

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    acc_d           = acc_q;
    sent_d          = sent_q;
    hold_d          = hold_q;
    hold_full_d     = hold_full_q;
    shift_d         = shift_q;
    n_bit_counter_d = n_bit_counter_q;
    lvl_d           = lvl_q;
    sub_d           = sub_q;
`ifdef JOYBUS_TX_CRC_EN
    crc_clr         = 1'b0;
`endif

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      acc_d       = acc_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && (byte_count != '0) && (byte_count <= MAX_CNT)) begin
          count_d         = byte_count;
          acc_d           = '0;
          sent_d          = '0;
          hold_full_d     = 1'b0;
          n_bit_counter_d = '0;
          lvl_d           = '0;
          sub_d           = '0;
          state_d         = S_FETCH;
`ifdef JOYBUS_TX_CRC_EN
          crc_clr         = 1'b1;
`endif
        end
      end

      S_FETCH: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          sent_d      = sent_q + CNT_W'(1);
          state_d     = S_BITS;
        end
      end

      S_BITS, S_CRC, S_STOP: begin
        // Level/bit position; all counters wrap to zero exactly at a byte boundary.
        if (sub_end) begin
          sub_d = '0;
          lvl_d = lvl_q + 2'd1;
          if (lvl_q == 2'd3) begin
            n_bit_counter_d = n_bit_counter_q + 3'd1;
            shift_d         = {shift_q[6:0], 1'b0};
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end

        if (state_q == S_STOP) begin
          if (lvl_end) state_d = S_DONE;
        end else if (bit_end) begin
          if (state_q == S_CRC) begin
            state_d = S_STOP;
          end else if (more_payload) begin
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              sent_d      = sent_q + CNT_W'(1);
            end else begin
              state_d = S_ABORT;
            end
          end else begin
`ifdef JOYBUS_TX_CRC_EN
            shift_d = crc_rem;
            state_d = S_CRC;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

      S_ABORT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the position being entered, so the pins come straight from flops.
  always_comb begin
    data_oe_d = 1'b0;
    data_tx_d = 1'b1;
    sym_d     = shift_d[7] ? ENC_ONE : ENC_ZERO;
    case (state_d)
      S_BITS, S_CRC: begin
        data_oe_d = 1'b1;
        data_tx_d = sym_d[~lvl_d];
      end
      S_STOP: begin
        if (lvl_d != 2'd3) begin
          data_oe_d = 1'b1;
          data_tx_d = ENC_STOP[~lvl_d];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      acc_q           <= '0;
      sent_q          <= '0;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      shift_q         <= '0;
      n_bit_counter_q <= '0;
      lvl_q           <= '0;
      sub_q           <= '0;
      data_tx_q       <= 1'b1;
      data_oe_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      acc_q           <= acc_d;
      sent_q          <= sent_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      shift_q         <= shift_d;
      n_bit_counter_q <= n_bit_counter_d;
      lvl_q           <= lvl_d;
      sub_q           <= sub_d;
      data_tx_q       <= data_tx_d;
      data_oe_q       <= data_oe_d;
      busy_q          <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q          <= (state_d == S_DONE);
      underrun_q      <= (state_d == S_DONE) && (state_q == S_ABORT);
    end
  end

  assign data_tx  = data_tx_q;
  assign data_oe  = data_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_joybus_tx_engine.sv
// Scoreboard bench for joybus_tx_engine: a line-code model queues the expected
// per-cycle line/done/underrun values and a monitor compares them as they appear.
module tb_joybus_tx_engine;

  localparam int LW   = 2;
  localparam int MAXB = 33;
  localparam int CW   = $clog2(MAXB + 1);
`ifdef JOYBUS_TX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] byte_count = '0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, data_tx, data_oe, busy, done, underrun;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  exp_q[$];   // {oe, tx, done, underrun} per cycle
  logic [7:0]  pay[$];
  bit          active = 1'b0;
  bit          flush_req = 1'b0;

  always #5 clk = ~clk;

  joybus_tx_engine #(.LEVEL_WIDTH(LW), .MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .sample_clk (clk),
    .reset      (reset),
    .start      (start),
    .byte_count (byte_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .data_tx    (data_tx),
    .data_oe    (data_oe),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Augmented-message polynomial long division (payload then eight zero bits).
  function automatic logic [7:0] ref_crc(input int n);
    logic [8:0] r;
    logic       b;
    r = '0;
    for (int k = 0; k <= n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        b = (k < n) ? pay[k][i] : 1'b0;
        r = {r[7:0], b};
        if (r[8]) r = r ^ 9'h185;
      end
    end
    return r[7:0];
  endfunction

  // A '1' is high for the last three quarters of its bit, a '0' for the last quarter.
  task automatic push_byte(input logic [7:0] v);
    logic hi;
    for (int i = 7; i >= 0; i--) begin
      for (int q = 0; q < 4; q++) begin
        hi = v[i] ? (q >= 1) : (q == 3);
        repeat (LW) exp_q.push_back({1'b1, hi, 2'b00});
      end
    end
  endtask

  task automatic push_expected(input int n, input int supply);
    int k;
    k = (supply < n) ? supply : n;
    for (int b = 0; b < k; b++) push_byte(pay[b]);
    if (supply < n) begin
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0111);
    end else begin
      if (CRC_EN) push_byte(ref_crc(n));
      repeat (2 * LW) exp_q.push_back(4'b1000);
      repeat (LW)     exp_q.push_back(4'b1100);
      repeat (LW)     exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0110);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e, got;
    got = {data_oe, data_tx, done, underrun};
    if (flush_req) begin
      exp_q.delete();
      active    = 1'b0;
      flush_req = 1'b0;
    end else begin
      if (!active && data_oe === 1'b1) active = 1'b1;
      if (active) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL line_unexpected: got oe/tx/done/und=%b want idle at %0t", got, $time);
          active = 1'b0;
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL line: got oe/tx/done/und=%b want %b at %0t", got, e, $time);
          end
          if (e[1]) active = 1'b0;
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL stray_done: got done=%b want 0 at %0t", done, $time);
        end
      end
    end
  end

  task automatic run_resp(input int n, input int supply, input bit junk, input bit gaps,
                          input int dup_at, input int rst_at);
    int idx, acc, gap, cyc, first_acc, first_oe;
    bit pend, fin;
    idx = 0; acc = 0; gap = 0; cyc = 0; first_acc = -1; first_oe = -1; pend = 0; fin = 0;
    push_expected(n, (rst_at < 0) ? supply : n);
    if (gaps) gap = $urandom_range(0, 8);
    start = 1'b1;
    byte_count = CW'(n);
    @(posedge clk); #1;
    cyc = 1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", tx_ready, 1);
    while (!fin && cyc < 5000) begin
      if (pend) begin
        pend = 0; idx++; acc++;
        if (gaps) gap = $urandom_range(0, 8);
      end
      if (data_oe && first_oe < 0) first_oe = cyc;
      if (done) begin
        fin = 1;
        check("busy_low_at_done", busy, 0);
        check("accept_count", acc, supply);
        check("first_level_latency", first_oe - first_acc, 2);
      end else if (rst_at >= 0 && first_oe >= 0 && cyc == first_oe + rst_at) begin
        reset = 1'b1; flush_req = 1'b1; tx_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_oe", data_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", tx_ready, 0);
        check("reset_done", done, 0);
        fin = 1;
      end else begin
        start = (cyc == dup_at);
        if (idx < supply) begin
          if (gap > 0) begin
            tx_valid = 1'b0;
            gap--;
          end else begin
            tx_valid = 1'b1;
            tx_data  = pay[idx];
          end
        end else if (junk && idx >= n) begin
          tx_valid = 1'b1;
          tx_data  = 8'($urandom);
        end else begin
          tx_valid = 1'b0;
        end
        pend = tx_valid && tx_ready;
        if (pend && first_acc < 0) first_acc = cyc;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: got no done after %0d cycles want done", cyc);
    end
    tx_valid = 1'b0;
    start    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run_ignored(input int cnt);
    start = 1'b1;
    byte_count = CW'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_busy", busy, 0);
    check("ignored_ready", tx_ready, 0);
    repeat (20) @(posedge clk);
    #1;
    check("ignored_busy_late", busy, 0);
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    int n, supply;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_ready", tx_ready, 0);
    check("reset_data_tx", data_tx, 1);
    check("reset_data_oe", data_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_underrun", underrun, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    pay.delete(); pay.push_back(8'h05); pay.push_back(8'h00); pay.push_back(8'h00);
    run_resp(3, 3, 0, 0, -1, -1);

    pay.delete(); repeat (4) pay.push_back(8'h00);
    run_resp(4, 4, 1, 0, -1, -1);

    pay.delete(); pay.push_back(8'h01);
    run_resp(1, 1, 0, 0, -1, -1);

    pay.delete(); repeat (32) pay.push_back(8'h00);
    run_resp(32, 32, 0, 1, -1, -1);

    pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C); pay.push_back(8'h7E);
    run_resp(3, 1, 0, 0, -1, -1);

    fill_rand(3);
    run_resp(3, 3, 0, 0, -1, 18);

    pay.delete(); pay.push_back(8'hC3); pay.push_back(8'h81);
    run_resp(2, 2, 0, 0, -1, -1);

    run_ignored(0);
    run_ignored(34);

    fill_rand(3);
    run_resp(3, 3, 0, 0, 40, -1);

    fill_rand(33);
    run_resp(33, 33, 1, 1, -1, -1);

    for (int t = 0; t < 16; t++) begin
      n = $urandom_range(1, 12);
      fill_rand(n);
      supply = (n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, n - 1)) : n;
      run_resp(n, supply, 1'($urandom_range(0, 1)), 1, -1, -1);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
